spi_flash_target: RTL and testbench
===================================

// Module: spi_flash_target
// PURPOSE
//  SPI mode-0 responder that emulates a small serial flash on the far end of one
//  spraid drive link. Oversamples spi_clk/spi_cs/spi_mosi in the system clock, decodes
//  READ/PROGRAM/WREN/WRDI/RDSR and drives a byte-wide backing-store port.
//  Used as a synthesizable drive model in RAID benches and as an FPGA flash stand-in.
// PARAMETERS
//  ADDR_W      16   byte-address width; address bytes on the wire = ADDR_W/8
//  PROG_CYCLES 64   clk cycles WIP stays set after a program commit (min 1)
// PORTS
//  clk        in   1       system clock; must be >= 4x spi_clk frequency
//  reset_n    in   1       asynchronous, active-low reset
//  spi_clk    in   1       SPI clock from initiator, idle low
//  spi_cs     in   1       chip select, active low
//  spi_mosi   in   1       initiator data, MSB first
//  spi_miso   out  1       responder data; 0 while spi_cs high
//  mem_addr   out  ADDR_W  backing-store byte address
//  mem_re     out  1       1-clk read strobe; mem_rdata valid next clk
//  mem_rdata  in   8       read data
//  mem_we     out  1       1-clk write strobe with mem_addr/mem_wdata
//  mem_wdata  out  8       write data
//  wip        out  1       program in progress (status bit 0)
//  wel        out  1       write-enable latch (status bit 1)
//  cmd_err    out  1       1-clk pulse: unknown opcode received
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, shift/bit counters 0, sync flops load idle
//    levels (spi_clk 0, spi_cs 1).
//  - 2-flop synchronizers on all three SPI inputs; edges detected from stage 2/3.
//  - MOSI sampled on detected spi_clk rise; MISO updated on detected spi_clk fall; MSB first.
//  - spi_cs fall: state CMD, bit count 0. spi_cs rise in any state: to IDLE, partial
//    byte discarded, miso 0; if state was PROG and >=1 byte written, start WIP.
//  - FSM: IDLE -> CMD -> {ADDR, RDSR, IGNORE}; ADDR -> READ | PROG; all -> IDLE on cs rise.
//  - CMD byte on 8th rise: 0x03 READ, 0x02 PROG -> ADDR; 0x05 -> RDSR;
//    0x06 sets wel, 0x04 clears wel -> IGNORE; other -> cmd_err pulse, IGNORE.
//  - While wip=1: 0x03/0x02/0x06/0x04 also go to IGNORE (no cmd_err); only RDSR served.
//  - 0x02 with wel=0 -> IGNORE; wel unchanged.
//  - ADDR: ADDR_W bits MSB first into address reg; on last rise: READ pulses mem_re.
//  - READ: rdata captured into shift reg clk after mem_re, before next fall; first data
//    bit on the fall after last address bit. After each byte's 8th rise,
//    addr+1 and next mem_re. Address wraps 2^ADDR_W-1 -> 0.
//  - PROG: each complete byte -> mem_we with current addr, then addr+1 (same wrap).
//  - RDSR: shifts {6'b0, wel, wip} repeatedly until cs rise; wip reflects live value per byte.
//  - WIP: wip=1 for PROG_CYCLES clks after commit, then wip<=0 and wel<=0 same clk.
//    Counter runs regardless of cs; reset_n low mid-operation aborts everything.
//  - mem_re/mem_we never asserted in same clk; at most one each per byte.
// STRUCTURE
//  - Shared package spraid_pkg: opcode localparams (OP_READ 8'h03, OP_PROG 8'h02,
//    OP_WREN 8'h06, OP_WRDI 8'h04, OP_RDSR 8'h05), FSM state encoding.
//  - One sub-module: spi_sync_edge (synchronizer + rise/fall detect), instanced for spi_clk,
//    spi_cs, spi_mosi. Remainder (FSM, shifters, addr counter, WIP timer) in top.
// TESTING
//  - Reset: reset_n low mid-READ -> all outputs 0; next cs frame decodes cleanly.
//  - WREN; PROG 0x1234 bytes A5,5A; cs high -> mem_we at 0x1234=A5, 0x1235=5A; wip=1
//    for 64 clks, then wip=0, wel=0.
//  - READ 0xFFFF, 3 bytes, mem holds FF:11,0000:22,0001:33 -> miso 11,22,33 (wrap).
//  - PROG without WREN -> no mem_we, wel=0; opcode 0xAB -> one cmd_err pulse, miso 0.
//  - RDSR polled during WIP -> 0x03 then 0x00 after timer expiry; READ issued during
//    WIP -> no mem_re.
//  - cs raised after 5 bits of PROG data byte -> no mem_we for that byte;
//    spi_clk at clk/4 passes all above.

Source files
------------

// File: rtl/spraid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spraid_pkg
// Description : Shared opcodes and FSM state encoding for the spraid drive
//               link flash emulation.
// Revision    : 1.0 - initial release
// ============================================================================
package spraid_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_PROG   = 3'd4,
        ST_RDSR   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage : spraid_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Two-flop synchronizer for one SPI pin plus a third history
//               flop for rise/fall detection in the system clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    logic [2:0] r_sync;

    // Shift the pin in; reset loads the pin's idle level so no false edge appears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {3{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[1:0], i_din};
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_sync[2];
    assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_flash_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_target
// Description : SPI mode-0 serial flash responder. Oversamples the SPI pins,
//               decodes READ/PROG/WREN/WRDI/RDSR and drives a byte-wide
//               backing-store port; models write-in-progress with a timer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_target
    import spraid_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int PROG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              wip,
    output logic              wel,
    output logic              cmd_err
);

    localparam int CNT_W = $clog2(ADDR_W);
    localparam int WIP_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  c_last_bit  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  c_last_addr = CNT_W'(ADDR_W - 1);
    localparam logic [WIP_W-1:0]  c_wip_load  = WIP_W'(PROG_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [7:0]         r_shift_in;
    logic [7:0]         r_shift_out;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_re, r_re_d, r_mem_we;
    logic [7:0]         r_mem_wdata;
    logic               r_miso, r_op_read, r_prog_wrote;
    logic               r_wip, r_wel, r_cmd_err;
    logic [WIP_W-1:0]   r_wip_cnt;

    logic               w_byte_done, w_addr_done;
    logic               w_set_wel, w_clr_wel, w_cmd_err, w_wip_start;
    logic [7:0]         w_in_byte, w_out_src, w_status;
    logic [ADDR_W-1:0]  w_addr_shift;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_din(spi_clk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .i_din(spi_cs),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_din(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = ^{w_sclk_level, w_cs_level, w_mosi_rise, w_mosi_fall};

    assign w_in_byte    = {r_shift_in[6:0], w_mosi};
    assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi};
    assign w_byte_done  = w_sclk_rise && (r_bit_cnt == c_last_bit);
    assign w_addr_done  = w_sclk_rise && (r_bit_cnt == c_last_addr);
    assign w_status     = {6'b0, r_wel, r_wip};
    // Read data may land on the same clk as the first fall; bypass it straight out
    assign w_out_src    = r_re_d ? mem_rdata : r_shift_out;
    // A program frame only commits if at least one whole byte was written
    assign w_wip_start  = w_cs_rise && (r_state == ST_PROG) && r_prog_wrote;

    // Next-state and command decode
    always_comb begin
        w_state_next = r_state;
        w_set_wel    = 1'b0;
        w_clr_wel    = 1'b0;
        w_cmd_err    = 1'b0;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else if (w_cs_fall) begin
            w_state_next = ST_CMD;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_byte_done) begin
                        w_state_next = ST_IGNORE;
                        case (w_in_byte)
                            OP_READ: if (!r_wip) w_state_next = ST_ADDR;
                            OP_PROG: if (!r_wip && r_wel) w_state_next = ST_ADDR;
                            OP_RDSR: w_state_next = ST_RDSR;
                            OP_WREN: w_set_wel = !r_wip;
                            OP_WRDI: w_clr_wel = !r_wip;
                            default: w_cmd_err = 1'b1;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_addr_done) begin
                        w_state_next = r_op_read ? ST_READ : ST_PROG;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shifters, address counter, memory strobes and status/WIP timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_re_d       <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_miso       <= 1'b0;
            r_op_read    <= 1'b0;
            r_prog_wrote <= 1'b0;
            r_wip        <= 1'b0;
            r_wel        <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_wip_cnt    <= '0;
        end else begin
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_re_d    <= r_mem_re;
            r_cmd_err <= w_cmd_err;

            if (w_wip_start) begin
                r_wip     <= 1'b1;
                r_wip_cnt <= c_wip_load;
            end else if (r_wip) begin
                if (r_wip_cnt == '0) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end else begin
                    r_wip_cnt <= r_wip_cnt - WIP_W'(1);
                end
            end
            if (w_set_wel) r_wel <= 1'b1;
            if (w_clr_wel) r_wel <= 1'b0;

            if (w_cs_rise || w_cs_fall) begin
                r_bit_cnt  <= '0;
                r_shift_in <= '0;
                r_miso     <= 1'b0;
                if (w_cs_fall) r_prog_wrote <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_in_byte;
                            r_bit_cnt  <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
                            if (w_byte_done) begin
                                r_op_read   <= (w_in_byte == OP_READ);
                                r_shift_out <= w_status;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr    <= w_addr_shift;
                            r_bit_cnt <= w_addr_done ? '0 : r_bit_cnt + CNT_W'(1);
                            if (w_addr_done && r_op_read) begin
                                r_mem_addr <= w_addr_shift;
                                r_addr     <= w_addr_shift + c_addr_one;
                                r_mem_re   <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
                            if (w_byte_done) begin
                                r_mem_addr <= r_addr;
                                r_addr     <= r_addr + c_addr_one;
                                r_mem_re   <= 1'b1;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_miso      <= w_out_src[7];
                            r_shift_out <= {w_out_src[6:0], 1'b0};
                        end else if (r_re_d) begin
                            r_shift_out <= mem_rdata;
                        end
                    end
                    ST_PROG: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_in_byte;
                            r_bit_cnt  <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
                            if (w_byte_done) begin
                                r_mem_we     <= 1'b1;
                                r_mem_wdata  <= w_in_byte;
                                r_mem_addr   <= r_addr;
                                r_addr       <= r_addr + c_addr_one;
                                r_prog_wrote <= 1'b1;
                            end
                        end
                    end
                    ST_RDSR: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
                            if (w_byte_done) r_shift_out <= w_status;
                        end
                        if (w_sclk_fall) begin
                            r_miso      <= r_shift_out[7];
                            r_shift_out <= {r_shift_out[6:0], 1'b0};
                        end
                    end
                    default: begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                endcase
            end
        end
    end

    // MISO is forced low the moment the initiator deselects, ahead of the synchronizer
    assign spi_miso  = r_miso & ~spi_cs;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign wip       = r_wip;
    assign wel       = r_wel;
    assign cmd_err   = r_cmd_err;

endmodule : spi_flash_target
`default_nettype wire

// File: tb/tb_spi_flash_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_target
// Description : Directed self-checking bench for spi_flash_target with a
//               byte-wide backing-store model and SPI initiator at clk/4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_target;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_clk, spi_cs, spi_mosi;
    logic        spi_miso;
    logic [15:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_rdata, mem_wdata;
    logic        wip, wel, cmd_err;

    int n_vec = 0;
    int n_err = 0;
    int re_cnt = 0, we_cnt = 0, err_cnt = 0, wip_cycles = 0, overlap_cnt = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];

    always #5 clk = ~clk;

    spi_flash_target #(.ADDR_W(16), .PROG_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .wip(wip), .wel(wel), .cmd_err(cmd_err)
    );

    // Backing store: registered read, write logged
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
        end
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (mem_re === 1'b1) re_cnt++;
        if (mem_we === 1'b1) we_cnt++;
        if (cmd_err === 1'b1) err_cnt++;
        if (wip === 1'b1) wip_cycles++;
        if (mem_re === 1'b1 && mem_we === 1'b1) overlap_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_begin();
        tick(1);
        spi_cs = 1'b0;
        tick(3);
    endtask

    task automatic cs_end();
        spi_clk = 1'b0;
        tick(3);
        spi_cs = 1'b1;
        tick(4);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[7-i];
            tick(2);
            spi_clk = 1'b1;
            tick(2);
            rx = {rx[6:0], spi_miso};
        end
    endtask

    task automatic frame_wren();
        logic [7:0] rx;
        cs_begin(); xfer(8'h06, 8, rx); cs_end();
    endtask

    task automatic test_reset();
        logic [7:0] rx;
        reset_n = 1'b0;
        tick(3);
        n_vec++;
        if ({mem_addr, mem_re, mem_we, mem_wdata, wip, wel, cmd_err, spi_miso} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_state: got addr=%h re=%b we=%b wd=%h wip=%b wel=%b err=%b miso=%b, expected all 0",
                     mem_addr, mem_re, mem_we, mem_wdata, wip, wel, cmd_err, spi_miso);
        end
        reset_n = 1'b1;
        tick(2);
        // READ 0x0010, one full byte then reset partway through the next
        cs_begin();
        xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
        xfer(8'h00, 8, rx);
        n_vec++;
        if (rx !== 8'h9E) begin
            n_err++; $display("FAIL pre_reset_read: got %h expected 9e", rx);
        end
        xfer(8'h00, 3, rx);
        spi_clk = 1'b0;
        tick(1);
        reset_n = 1'b0;
        #2;
        n_vec++;
        if ({mem_addr, mem_re, mem_we, mem_wdata, wip, wel, cmd_err, spi_miso} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_mid_read: got addr=%h re=%b we=%b wd=%h wip=%b wel=%b err=%b miso=%b, expected all 0",
                     mem_addr, mem_re, mem_we, mem_wdata, wip, wel, cmd_err, spi_miso);
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        spi_cs = 1'b1;
        tick(4);
        cs_begin();
        xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
        xfer(8'h00, 8, rx);
        cs_end();
        n_vec++;
        if (rx !== 8'h9E) begin
            n_err++; $display("FAIL post_reset_read: got %h expected 9e", rx);
        end
    endtask

    task automatic test_program();
        logic [7:0] rx;
        frame_wren();
        n_vec++;
        if (wel !== 1'b1) begin
            n_err++; $display("FAIL wren_sets_wel: got %b expected 1", wel);
        end
        we_addr_q.delete(); we_data_q.delete();
        wip_cycles = 0;
        cs_begin();
        xfer(8'h02, 8, rx); xfer(8'h12, 8, rx); xfer(8'h34, 8, rx);
        xfer(8'hA5, 8, rx); xfer(8'h5A, 8, rx);
        cs_end();
        n_vec++;
        if (we_addr_q.size() !== 2) begin
            n_err++; $display("FAIL prog_write_count: got %0d expected 2", we_addr_q.size());
        end else begin
            n_vec++;
            if ({we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]} !== 48'h1234_A5_1235_5A) begin
                n_err++;
                $display("FAIL prog_writes: got %h=%h %h=%h expected 1234=a5 1235=5a",
                         we_addr_q[0], we_data_q[0], we_addr_q[1], we_data_q[1]);
            end
        end
        n_vec++;
        if (wip !== 1'b1) begin
            n_err++; $display("FAIL wip_after_commit: got %b expected 1", wip);
        end
        // Status poll while the program timer runs
        cs_begin();
        xfer(8'h05, 8, rx); xfer(8'h00, 8, rx);
        cs_end();
        n_vec++;
        if (rx !== 8'h03) begin
            n_err++; $display("FAIL rdsr_during_wip: got %h expected 03", rx);
        end
        tick(100);
        n_vec++;
        if (wip_cycles !== 64) begin
            n_err++; $display("FAIL wip_duration: got %0d cycles expected 64", wip_cycles);
        end
        n_vec++;
        if ({wip, wel} !== 2'b00) begin
            n_err++; $display("FAIL wip_expiry: got wip=%b wel=%b expected 0 0", wip, wel);
        end
        cs_begin();
        xfer(8'h05, 8, rx); xfer(8'h00, 8, rx);
        cs_end();
        n_vec++;
        if (rx !== 8'h00) begin
            n_err++; $display("FAIL rdsr_after_wip: got %h expected 00", rx);
        end
    endtask

    task automatic test_read_during_wip();
        logic [7:0] rx;
        frame_wren();
        cs_begin();
        xfer(8'h02, 8, rx); xfer(8'h01, 8, rx); xfer(8'h00, 8, rx); xfer(8'h77, 8, rx);
        cs_end();
        re_cnt = 0;
        cs_begin();
        xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx); xfer(8'h00, 8, rx);
        cs_end();
        n_vec++;
        if (re_cnt !== 0) begin
            n_err++; $display("FAIL read_during_wip: got %0d mem_re expected 0", re_cnt);
        end
        tick(100);
    endtask

    task automatic test_read_wrap();
        logic [7:0] rx;
        logic [23:0] got;
        re_cnt = 0;
        cs_begin();
        xfer(8'h03, 8, rx); xfer(8'hFF, 8, rx); xfer(8'hFF, 8, rx);
        xfer(8'h00, 8, rx); got[23:16] = rx;
        xfer(8'h00, 8, rx); got[15:8]  = rx;
        xfer(8'h00, 8, rx); got[7:0]   = rx;
        cs_end();
        n_vec++;
        if (got !== 24'h112233) begin
            n_err++; $display("FAIL read_wrap_data: got %h expected 112233", got);
        end
        n_vec++;
        if (re_cnt !== 4) begin
            n_err++; $display("FAIL read_wrap_strobes: got %0d mem_re expected 4", re_cnt);
        end
    endtask

    task automatic test_prog_no_wren();
        logic [7:0] rx;
        we_cnt = 0;
        cs_begin();
        xfer(8'h02, 8, rx); xfer(8'h20, 8, rx); xfer(8'h00, 8, rx); xfer(8'hAA, 8, rx);
        cs_end();
        n_vec++;
        if ({we_cnt[7:0], wel, wip} !== 10'd0) begin
            n_err++; $display("FAIL prog_no_wren: got we=%0d wel=%b wip=%b expected 0 0 0", we_cnt, wel, wip);
        end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx;
        err_cnt = 0;
        cs_begin();
        xfer(8'hAB, 8, rx); xfer(8'h00, 8, rx);
        cs_end();
        n_vec++;
        if (err_cnt !== 1) begin
            n_err++; $display("FAIL bad_opcode_pulse: got %0d cmd_err expected 1", err_cnt);
        end
        n_vec++;
        if (rx !== 8'h00) begin
            n_err++; $display("FAIL bad_opcode_miso: got %h expected 00", rx);
        end
    endtask

    task automatic test_partial_byte();
        logic [7:0] rx;
        frame_wren();
        we_addr_q.delete(); we_data_q.delete();
        cs_begin();
        xfer(8'h02, 8, rx); xfer(8'h03, 8, rx); xfer(8'h00, 8, rx);
        xfer(8'h5C, 8, rx); xfer(8'hFF, 5, rx);
        cs_end();
        n_vec++;
        if (we_addr_q.size() !== 1) begin
            n_err++; $display("FAIL partial_write_count: got %0d expected 1", we_addr_q.size());
        end else begin
            n_vec++;
            if ({we_addr_q[0], we_data_q[0]} !== 24'h0300_5C) begin
                n_err++; $display("FAIL partial_write: got %h=%h expected 0300=5c", we_addr_q[0], we_data_q[0]);
            end
        end
        n_vec++;
        if (wip !== 1'b1) begin
            n_err++; $display("FAIL partial_commit_wip: got %b expected 1", wip);
        end
        tick(100);
        n_vec++;
        if (overlap_cnt !== 0) begin
            n_err++; $display("FAIL re_we_overlap: got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        spi_clk  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h9E;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'h33;
        test_reset();
        test_program();
        test_read_during_wip();
        test_read_wrap();
        test_prog_no_wren();
        test_bad_opcode();
        test_partial_byte();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_spi_flash_target
`default_nettype wire
